// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter (din / wr_en / tx_busy)
//   among NUM_REQ byte-stream requesters. A grant is held for a whole packet
//   (up to the byte flagged req_last) or, when MAX_BURST is non-zero, for at
//   most MAX_BURST data bytes. Each grant may be prefixed by a header byte
//   HEADER_BASE | id. Bytes are paced strictly by the tx_busy handshake: every
//   strobe is followed by a wait for busy to rise (or a BUSY_TO timeout) and
//   then a wait for busy to fall.
//
// Ports
//   system_clk   in   clock
//   reset        in   asynchronous, active-high reset
//   req_valid    in   [NUM_REQ]    per-requester byte valid
//   req_data     in   [8*NUM_REQ]  per-requester byte, requester i at [8i+7:8i]
//   req_last     in   [NUM_REQ]    byte is the last of its packet
//   req_ready    out  [NUM_REQ]    byte accepted this cycle (one-hot or zero)
//   uart_din     out  [8]          byte to the transmitter
//   uart_wr_en   out               one-cycle write strobe
//   uart_tx_busy in                transmitter busy
//   grant_id     out  [3]          current / last granted requester
//   active       out               packet in progress
module uart_tx_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BASE = 8'hA0,
  parameter int         MAX_BURST   = 0,
  parameter int         BUSY_TO     = 4
) (
  input  logic                   system_clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_din,
  output logic                   uart_wr_en,
  input  logic                   uart_tx_busy,
  output logic [2:0]             grant_id,
  output logic                   active
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;

  logic [2:0]         state_r;
  logic [2:0]         grant_id_r;
  logic [7:0]         din_r;
  logic               wr_en_r;
  logic               last_r;
  logic               hdr_r;
  logic [15:0]        burst_cnt_r;
  logic [15:0]        to_cnt_r;

  logic [2:0]         next_grant_s;
  logic               any_s;
  logic [7:0]         sel_data_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic               xfer_s;
  logic               to_done_s;
  logic               burst_hit_s;
  logic [NUM_REQ-1:0] req_ready_s;

  // Round-robin search: first valid requester starting at grant_id+1, wrapping.
  // The requester that was just served is therefore examined last.
  always_comb begin
    next_grant_s = grant_id_r;
    any_s        = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_s && req_valid[i] && (((int'(grant_id_r) + k) % NUM_REQ) == i)) begin
          any_s        = 1'b1;
          next_grant_s = 3'(i);
        end else begin
          next_grant_s = next_grant_s;
        end
      end
    end
  end

  // Route the granted requester's byte, valid and last flag.
  always_comb begin
    sel_data_s  = 8'h00;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_r == 3'(i)) begin
        sel_data_s  = req_data[8*i +: 8];
        sel_valid_s = req_valid[i];
        sel_last_s  = req_last[i];
      end else begin
        sel_data_s  = sel_data_s;
      end
    end
  end

  // Ready is offered only to the granted requester, only in DATA with the transmitter idle.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_r == ST_DATA) && !uart_tx_busy && (grant_id_r == 3'(i))) begin
        req_ready_s[i] = 1'b1;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  assign xfer_s      = sel_valid_s && (state_r == ST_DATA) && !uart_tx_busy;
  // to_cnt_r counts WAIT_HI cycles starting with the strobe cycle itself.
  assign to_done_s   = (to_cnt_r + 16'd1) >= 16'(BUSY_TO);
  assign burst_hit_s = (MAX_BURST != 0) && (burst_cnt_r == 16'(MAX_BURST));

  // Arbitration / pacing state machine.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      grant_id_r  <= 3'(NUM_REQ - 1);
      din_r       <= 8'h00;
      wr_en_r     <= 1'b0;
      last_r      <= 1'b0;
      hdr_r       <= 1'b0;
      burst_cnt_r <= 16'd0;
      to_cnt_r    <= 16'd0;
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            grant_id_r <= next_grant_s;
            state_r    <= (HEADER_EN != 0) ? ST_HDR : ST_DATA;
          end
        end
        ST_HDR: begin
          if (!uart_tx_busy) begin
            din_r    <= HEADER_BASE | {5'b00000, grant_id_r};
            wr_en_r  <= 1'b1;
            hdr_r    <= 1'b1;
            to_cnt_r <= 16'd0;
            state_r  <= ST_WAIT_HI;
          end
        end
        ST_DATA: begin
          // No preemption: with no valid byte the grant is simply held.
          if (xfer_s) begin
            din_r       <= sel_data_s;
            wr_en_r     <= 1'b1;
            hdr_r       <= 1'b0;
            last_r      <= sel_last_s;
            burst_cnt_r <= (burst_cnt_r == 16'hFFFF) ? burst_cnt_r : burst_cnt_r + 16'd1;
            to_cnt_r    <= 16'd0;
            state_r     <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (uart_tx_busy || to_done_s) begin
            state_r <= ST_WAIT_LO;
          end else begin
            to_cnt_r <= to_cnt_r + 16'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!uart_tx_busy) begin
            if (hdr_r) begin
              state_r <= ST_DATA;
            end else if (last_r || burst_hit_s) begin
              state_r     <= ST_IDLE;
              burst_cnt_r <= 16'd0;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign uart_din   = din_r;
  assign uart_wr_en = wr_en_r;
  assign grant_id   = grant_id_r;
  assign active     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Two instances: g_env[0] unlimited bursts,
// g_env[1] MAX_BURST=2. Each has a requester driver fed from byte queues,
// a transmitter busy model and a monitor that pops expected bytes from a
// scoreboard queue on every write strobe.
module tb_uart_tx_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc;

  logic [8:0] rq [8][$];      // {last, byte} per requester; 0..3 -> inst 0, 4..7 -> inst 1
  logic [7:0] exp_q [2][$];   // expected transmitter bytes per instance
  int         busy_len [2];
  logic       busy_dead [2];
  logic       t3_on;

  logic [7:0] din_m [2];
  logic       wr_m [2];
  logic       active_m [2];
  logic [3:0] ready_m [2];
  logic [2:0] grant_m [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_env
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [7:0]  uart_din;
    logic        uart_wr_en;
    logic        uart_tx_busy;
    logic        active;
    logic [2:0]  grant_id;
    int          wr_count = 0;

    uart_tx_arbiter #(
      .NUM_REQ(4), .HEADER_EN(1), .HEADER_BASE(8'hA0),
      .MAX_BURST((d == 1) ? 2 : 0), .BUSY_TO(4)
    ) dut (
      .system_clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .uart_din(uart_din), .uart_wr_en(uart_wr_en),
      .uart_tx_busy(uart_tx_busy), .grant_id(grant_id), .active(active)
    );

    assign din_m[d]    = uart_din;
    assign wr_m[d]     = uart_wr_en;
    assign active_m[d] = active;
    assign ready_m[d]  = req_ready;
    assign grant_m[d]  = grant_id;

    // Requesters: present the head of each queue, pop it when valid&ready.
    initial begin : drv
      logic [3:0]  xf;
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] dd;
      logic [8:0]  e;
      req_valid = 4'h0;
      req_last  = 4'h0;
      req_data  = 32'h0;
      forever begin
        @(negedge clk);
        xf = req_valid & req_ready;
        @(posedge clk);
        #2;
        v  = 4'h0;
        l  = 4'h0;
        dd = 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (xf[i] && rq[4*d+i].size() > 0) void'(rq[4*d+i].pop_front());
          if (rq[4*d+i].size() > 0) begin
            e = rq[4*d+i][0];
            v[i] = 1'b1;
            l[i] = e[8];
            dd[8*i +: 8] = e[7:0];
          end
        end
        req_valid = v;
        req_last  = l;
        req_data  = dd;
      end
    end

    // Transmitter: busy from the cycle after a strobe for busy_len cycles.
    initial begin : txm
      int   bcnt;
      logic w;
      bcnt = 0;
      uart_tx_busy = 1'b0;
      forever begin
        @(negedge clk);
        w = uart_wr_en;
        @(posedge clk);
        #1;
        if (bcnt > 0) bcnt--;
        if (w && !busy_dead[d]) bcnt = busy_len[d];
        uart_tx_busy = (bcnt != 0);
      end
    end

    // Monitor: scoreboard pop on every strobe plus handshake rules.
    initial begin : mon
      logic       prev_wr;
      int         last_cyc;
      logic [7:0] e;
      prev_wr  = 1'b0;
      last_cyc = -1;
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (req_ready != 4'h0) check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
          if (t3_on && active && grant_id == 3'd1) check("t3_req2_ready_low", 32'(req_ready[2]), 32'd0);
          if (uart_wr_en) begin
            wr_count++;
            check("wr_en_while_busy", 32'(uart_tx_busy), 32'd0);
            check("wr_en_one_cycle", 32'(prev_wr), 32'd0);
            if (exp_q[d].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_byte: got %0h expected none", uart_din);
            end else begin
              e = exp_q[d].pop_front();
              check("uart_din", 32'(uart_din), 32'(e));
            end
            if (busy_dead[d] && last_cyc >= 0)
              check("busy_to_gap", 32'(((cyc - last_cyc) >= 6) && ((cyc - last_cyc) <= 7)), 32'd1);
            last_cyc = cyc;
          end
          prev_wr = uart_wr_en;
        end else begin
          prev_wr  = 1'b0;
          last_cyc = -1;
        end
      end
    end
  end

  task automatic load(input int k, input logic [7:0] b, input logic last);
    rq[k].push_back({last, b});
  endtask

  task automatic expect_b(input int d, input logic [7:0] b);
    exp_q[d].push_back(b);
  endtask

  function automatic logic rq_empty(input int d);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 4; i++) if (rq[4*d+i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int d, input string name);
    int n;
    n = 0;
    while ((exp_q[d].size() != 0 || active_m[d] || !rq_empty(d)) && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, 32'(n < 600), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    t3_on    = 1'b0;
    busy_len[0] = 3;  busy_len[1] = 3;
    busy_dead[0] = 1'b0;  busy_dead[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_din", 32'(din_m[0]), 32'h00);
    check("rst_wr_en", 32'(wr_m[0]), 32'd0);
    check("rst_ready", 32'(ready_m[0]), 32'd0);
    check("rst_grant", 32'(grant_m[0]), 32'd3);
    check("rst_active", 32'(active_m[0]), 32'd0);
    reset = 1'b0;

    // T1: single packet from req0
    @(posedge clk);
    #1;
    load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b1);
    expect_b(0, 8'hA0); expect_b(0, 8'h11); expect_b(0, 8'h22);
    wait_idle(0, "t1");
    check("t1_grant", 32'(grant_m[0]), 32'd0);

    // T2: four one-byte packets at once, served 0..3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(i, 8'h30 + 8'(i), 1'b1);
      expect_b(0, 8'hA0 + 8'(i));
      expect_b(0, 8'h30 + 8'(i));
    end
    wait_idle(0, "t2");
    check("t2_active", 32'(active_m[0]), 32'd0);
    check("t2_grant", 32'(grant_m[0]), 32'd3);

    // T3: req1 packet of 3 bytes is not preempted by req2
    do_reset();
    t3_on = 1'b1;
    load(1, 8'h41, 1'b0); load(1, 8'h42, 1'b0); load(1, 8'h43, 1'b1);
    load(2, 8'h51, 1'b1);
    expect_b(0, 8'hA1); expect_b(0, 8'h41); expect_b(0, 8'h42); expect_b(0, 8'h43);
    expect_b(0, 8'hA2); expect_b(0, 8'h51);
    wait_idle(0, "t3");
    t3_on = 1'b0;
    check("t3_grant", 32'(grant_m[0]), 32'd2);

    // T4: MAX_BURST=2 splits req0's 5-byte packet around req3's packet
    do_reset();
    for (int i = 0; i < 5; i++) load(4, 8'h60 + 8'(i), (i == 4));
    load(7, 8'h70, 1'b0); load(7, 8'h71, 1'b1);
    expect_b(1, 8'hA0); expect_b(1, 8'h60); expect_b(1, 8'h61);
    expect_b(1, 8'hA3); expect_b(1, 8'h70); expect_b(1, 8'h71);
    expect_b(1, 8'hA0); expect_b(1, 8'h62); expect_b(1, 8'h63);
    expect_b(1, 8'hA0); expect_b(1, 8'h64);
    wait_idle(1, "t4");
    check("t4_grant", 32'(grant_m[1]), 32'd0);

    // T5: transmitter never signals busy; progress relies on the timeout
    busy_dead[0] = 1'b1;
    do_reset();
    load(0, 8'h81, 1'b0); load(0, 8'h82, 1'b1);
    expect_b(0, 8'hA0); expect_b(0, 8'h81); expect_b(0, 8'h82);
    wait_idle(0, "t5");
    busy_dead[0] = 1'b0;

    // T6: reset in WAIT_LO mid-packet, then req0 again wins first
    busy_len[0] = 6;
    do_reset();
    base = g_env[0].wr_count;
    load(0, 8'h91, 1'b0); load(0, 8'h92, 1'b0); load(0, 8'h93, 1'b1);
    expect_b(0, 8'hA0); expect_b(0, 8'h91);
    n = 0;
    while (g_env[0].wr_count < base + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_reach_byte", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    check("t6_active_before", 32'(active_m[0]), 32'd1);
    load(1, 8'hB1, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_din", 32'(din_m[0]), 32'h00);
    check("t6_rst_wr_en", 32'(wr_m[0]), 32'd0);
    check("t6_rst_ready", 32'(ready_m[0]), 32'd0);
    check("t6_rst_grant", 32'(grant_m[0]), 32'd3);
    check("t6_rst_active", 32'(active_m[0]), 32'd0);
    expect_b(0, 8'hA0); expect_b(0, 8'h92); expect_b(0, 8'h93);
    expect_b(0, 8'hA1); expect_b(0, 8'hB1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_idle(0, "t6");
    check("t6_grant", 32'(grant_m[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
